mark_lookup_arbiter: RTL and testbench

- Shares one mark_for_codepoint HLS component instance among NUM_REQ independent requesters.
- Arbitrates call requests round-robin and drives the component call interface (start/busy, c).
- Tracks in-flight calls in an in-order tag FIFO and steers each returndata back to the requester that issued it.
- Sits between the unicode-property lookup clients and the single mark_for_codepoint instance.

---
 rtl/mark_lookup_arbiter.sv | 156 +++++++++++++++
 tb/tb_mark_lookup_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mark_lookup_arbiter.sv
// Shares one mark_for_codepoint component among NUM_REQ requesters: round-robin call
// arbitration with stall lock, in-order tag FIFO that steers each return to its issuer.
module mark_lookup_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [32*NUM_REQ-1:0]      req_cp,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [31:0]                rsp_data,
    output logic                       comp_start,
    input  logic                       comp_busy,
    output logic [31:0]                comp_c,
    input  logic                       comp_done,
    output logic                       comp_stall,
    input  logic [31:0]                comp_returndata,
    output logic [$clog2(MAX_OUT):0]   outstanding,
    output logic                       err_orphan
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PTR_W  = $clog2(MAX_OUT);
    localparam int unsigned CNT_W  = PTR_W + 1;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             lock_q, lock_d;
    logic [ID_W-1:0]  locked_id_q, locked_id_d;
    logic [ID_W-1:0]  fifo_q [MAX_OUT];
    logic [ID_W-1:0]  fifo_d [MAX_OUT];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_orphan_q, err_orphan_d;

    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  cand;
    logic             found;
    logic             not_full;
    logic             not_empty;
    logic             accept;
    logic             push;
    logic             pop;
    logic [ID_W-1:0]  head;

    // Round-robin search starting just after the last accepted requester
    always_comb begin
        grant = locked_id_q;
        cand  = '0;
        found = 1'b0;
        if (!lock_q) begin
            grant = ptr_q;
            for (int k = 1; k <= int'(NUM_REQ); k++) begin
                cand = ID_W'((int'(ptr_q) + k) % int'(NUM_REQ));
                if (!found && req_valid[cand]) begin
                    grant = cand;
                    found = 1'b1;
                end
            end
        end
    end

    assign not_full   = (count_q != CNT_W'(MAX_OUT));
    assign not_empty  = (count_q != '0);
    // Gated by resetn so the call strobe drops the moment reset is asserted
    assign comp_start = resetn && ((|req_valid) || lock_q) && not_full;
    assign accept     = comp_start && !comp_busy;
    assign push       = accept;
    assign head       = fifo_q[rd_ptr_q];
    assign comp_stall = not_empty && !rsp_ready[head];
    assign pop        = comp_done && not_empty && !comp_stall;
    assign rsp_data   = comp_returndata;
    assign outstanding = count_q;
    assign err_orphan  = err_orphan_q;

    always_comb begin
        comp_c    = '0;
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant == ID_W'(i)) begin
                comp_c       = req_cp[DATA_W*i +: DATA_W];
                req_ready[i] = accept;
            end
            if (head == ID_W'(i)) begin
                rsp_valid[i] = comp_done && not_empty;
            end
        end
    end

    // Lock keeps the stalled call (and its codepoint) pinned until the component accepts it
    always_comb begin
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        ptr_d       = ptr_q;
        if (accept) begin
            lock_d = 1'b0;
            ptr_d  = grant;
        end else if (comp_start && comp_busy) begin
            lock_d      = 1'b1;
            locked_id_d = grant;
        end
    end

    always_comb begin
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        err_orphan_d = err_orphan_q;
        if (push) begin
            fifo_d[wr_ptr_q] = grant;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (comp_done && !not_empty) begin
            err_orphan_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ptr_q        <= ID_W'(NUM_REQ - 1);
            lock_q       <= 1'b0;
            locked_id_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_orphan_q <= 1'b0;
            for (int i = 0; i < int'(MAX_OUT); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            lock_q       <= lock_d;
            locked_id_q  <= locked_id_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_orphan_q <= err_orphan_d;
            fifo_q       <= fifo_d;
        end
    end

endmodule

// File: tb/tb_mark_lookup_arbiter.sv
// Scoreboard bench for mark_lookup_arbiter: expected grants and returns are queued as
// stimulus is driven and checked by a monitor when the DUT presents them.
module tb_mark_lookup_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned ID_W    = 2;

    logic                     clock;
    logic                     resetn;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [32*NUM_REQ-1:0]    req_cp;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [31:0]              rsp_data;
    logic                     comp_start;
    logic                     comp_busy;
    logic [31:0]              comp_c;
    logic                     comp_done;
    logic                     comp_stall;
    logic [31:0]              comp_returndata;
    logic [$clog2(MAX_OUT):0] outstanding;
    logic                     err_orphan;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t gq[$];
    exp_t rq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    mark_lookup_arbiter #(.NUM_REQ(NUM_REQ), .MAX_OUT(MAX_OUT), .ID_W(ID_W)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_cp(req_cp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .comp_start(comp_start), .comp_busy(comp_busy), .comp_c(comp_c),
        .comp_done(comp_done), .comp_stall(comp_stall), .comp_returndata(comp_returndata),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cp(input int i, input logic [31:0] v);
        req_cp[32*i +: 32] = v;
    endtask

    task automatic push_grant(input int id, input logic [31:0] cp);
        gq.push_back('{id: 8'(id), data: cp});
    endtask

    task automatic push_rsp(input int id, input logic [31:0] d);
        rq.push_back('{id: 8'(id), data: d});
    endtask

    // Monitor: every accepted call and every delivered result is matched against the queues
    always @(negedge clock) begin
        exp_t e;
        if (resetn) begin
            if (req_ready != '0) begin
                if (gq.size() == 0) begin
                    check_eq("grant_unexpected", 64'(req_ready), 64'(0));
                end else begin
                    e = gq.pop_front();
                    check_eq("grant_onehot", 64'(req_ready), 64'(1) << e.id);
                    check_eq("grant_cp", 64'(comp_c), 64'(e.data));
                end
            end
            if (rsp_valid != '0 && !comp_stall) begin
                if (rq.size() == 0) begin
                    check_eq("rsp_unexpected", 64'(rsp_valid), 64'(0));
                end else begin
                    e = rq.pop_front();
                    check_eq("rsp_onehot", 64'(rsp_valid), 64'(1) << e.id);
                    check_eq("rsp_data", 64'(rsp_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        resetn          = 1'b0;
        req_valid       = 4'b1111;
        req_cp          = '0;
        rsp_ready       = 4'b1111;
        comp_busy       = 1'b0;
        comp_done       = 1'b0;
        comp_returndata = '0;
        #2;
        check_eq("rst_comp_start", 64'(comp_start), 64'(0));
        check_eq("rst_req_ready", 64'(req_ready), 64'(0));
        check_eq("rst_outstanding", 64'(outstanding), 64'(0));
        check_eq("rst_err_orphan", 64'(err_orphan), 64'(0));
        req_valid = '0;
        tick();
        resetn = 1'b1;

        // Single call from requester 0, returned two cycles later
        req_valid = 4'b0001;
        set_cp(0, 32'h0301);
        push_grant(0, 32'h0301);
        #1;
        check_eq("single_start", 64'(comp_start), 64'(1));
        check_eq("single_occ0", 64'(outstanding), 64'(0));
        tick();
        req_valid = '0;
        check_eq("single_occ1", 64'(outstanding), 64'(1));
        tick();
        comp_done       = 1'b1;
        comp_returndata = 32'h1;
        push_rsp(0, 32'h1);
        #1;
        check_eq("single_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
        tick();
        comp_done = 1'b0;
        check_eq("single_occ_end", 64'(outstanding), 64'(0));

        // Round-robin from fresh reset until the FIFO fills
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_cp(i, 32'h100 + 32'(i));
            push_grant(i, 32'h100 + 32'(i));
        end
        req_valid = 4'b1111;
        repeat (4) tick();
        check_eq("rr_full_start", 64'(comp_start), 64'(0));
        check_eq("rr_full_ready", 64'(req_ready), 64'(0));
        check_eq("rr_full_occ", 64'(outstanding), 64'(4));
        req_valid = '0;
        comp_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            comp_returndata = 32'h10 + 32'(i);
            push_rsp(i, 32'h10 + 32'(i));
            tick();
        end
        comp_done = 1'b0;
        check_eq("rr_drain_occ", 64'(outstanding), 64'(0));

        // Stall lock: last grant was 3, so requester 1 wins and stays pinned while busy
        set_cp(1, 32'h0A01);
        set_cp(2, 32'h0A02);
        req_valid = 4'b0110;
        comp_busy = 1'b1;
        #1;
        check_eq("lock_c0", 64'(comp_c), 64'(32'h0A01));
        check_eq("lock_ready0", 64'(req_ready), 64'(0));
        tick();
        req_valid = 4'b0100;
        #1;
        check_eq("lock_c1", 64'(comp_c), 64'(32'h0A01));
        tick();
        check_eq("lock_c2", 64'(comp_c), 64'(32'h0A01));
        check_eq("lock_start", 64'(comp_start), 64'(1));
        tick();
        comp_busy = 1'b0;
        push_grant(1, 32'h0A01);
        tick();
        push_grant(2, 32'h0A02);
        tick();
        req_valid = '0;
        check_eq("lock_occ", 64'(outstanding), 64'(2));
        comp_done       = 1'b1;
        comp_returndata = 32'h21;
        push_rsp(1, 32'h21);
        tick();
        comp_returndata = 32'h22;
        push_rsp(2, 32'h22);
        tick();
        comp_done = 1'b0;

        // Return backpressure: calls from 2 then 0; requester 2 not ready for two cycles
        set_cp(2, 32'h0C02);
        set_cp(0, 32'h0C00);
        req_valid = 4'b0100;
        push_grant(2, 32'h0C02);
        tick();
        req_valid = 4'b0001;
        push_grant(0, 32'h0C00);
        tick();
        req_valid       = '0;
        rsp_ready       = 4'b1011;
        comp_done       = 1'b1;
        comp_returndata = 32'hA;
        push_rsp(2, 32'hA);
        push_rsp(0, 32'hB);
        #1;
        check_eq("bp_stall0", 64'(comp_stall), 64'(1));
        check_eq("bp_valid0", 64'(rsp_valid), 64'(4'b0100));
        tick();
        check_eq("bp_stall1", 64'(comp_stall), 64'(1));
        check_eq("bp_occ", 64'(outstanding), 64'(2));
        tick();
        rsp_ready = 4'b1111;
        #1;
        check_eq("bp_stall2", 64'(comp_stall), 64'(0));
        tick();
        comp_returndata = 32'hB;
        #1;
        check_eq("bp_valid1", 64'(rsp_valid), 64'(4'b0001));
        tick();
        comp_done = 1'b0;
        check_eq("bp_occ_end", 64'(outstanding), 64'(0));

        // Simultaneous push and pop at occupancy 2
        set_cp(1, 32'h0B01);
        set_cp(3, 32'h0B03);
        set_cp(0, 32'h0B00);
        req_valid = 4'b0010;
        push_grant(1, 32'h0B01);
        tick();
        req_valid = 4'b1000;
        push_grant(3, 32'h0B03);
        tick();
        check_eq("pp_occ_before", 64'(outstanding), 64'(2));
        req_valid       = 4'b0001;
        comp_done       = 1'b1;
        comp_returndata = 32'h31;
        push_grant(0, 32'h0B00);
        push_rsp(1, 32'h31);
        tick();
        req_valid = '0;
        check_eq("pp_occ_after", 64'(outstanding), 64'(2));
        comp_returndata = 32'h33;
        push_rsp(3, 32'h33);
        tick();
        comp_returndata = 32'h30;
        push_rsp(0, 32'h30);
        tick();
        comp_done = 1'b0;
        check_eq("pp_occ_end", 64'(outstanding), 64'(0));

        // Orphan return with empty FIFO
        comp_done       = 1'b1;
        comp_returndata = 32'h99;
        #1;
        check_eq("orph_stall", 64'(comp_stall), 64'(0));
        check_eq("orph_valid", 64'(rsp_valid), 64'(0));
        tick();
        comp_done = 1'b0;
        check_eq("orph_set", 64'(err_orphan), 64'(1));
        tick();
        check_eq("orph_sticky", 64'(err_orphan), 64'(1));

        // Three calls in flight, then asynchronous reset mid-operation
        for (int i = 0; i < 4; i++) set_cp(i, 32'h0E00 + 32'(i));
        req_valid = 4'b1111;
        push_grant(1, 32'h0E01);
        push_grant(2, 32'h0E02);
        push_grant(3, 32'h0E03);
        repeat (3) tick();
        check_eq("rst_mid_occ", 64'(outstanding), 64'(3));
        resetn = 1'b0;
        #1;
        check_eq("rst_mid_start", 64'(comp_start), 64'(0));
        check_eq("rst_mid_ready", 64'(req_ready), 64'(0));
        check_eq("rst_mid_occ0", 64'(outstanding), 64'(0));
        check_eq("rst_mid_orphan", 64'(err_orphan), 64'(0));
        check_eq("rst_mid_stall", 64'(comp_stall), 64'(0));
        check_eq("rst_mid_valid", 64'(rsp_valid), 64'(0));
        tick();
        resetn = 1'b1;
        push_grant(0, 32'h0E00);
        tick();
        req_valid = '0;
        check_eq("post_rst_occ", 64'(outstanding), 64'(1));
        comp_done       = 1'b1;
        comp_returndata = 32'h77;
        push_rsp(0, 32'h77);
        tick();
        comp_done = 1'b0;
        check_eq("post_rst_occ_end", 64'(outstanding), 64'(0));
        tick();

        check_eq("grant_queue_empty", 64'(gq.size()), 64'(0));
        check_eq("rsp_queue_empty", 64'(rq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
